// File: rtl/manor_pkg.sv
//============================================================================
// Package  : manor_pkg
// Summary  : Shared types and default timing constants for the manor
//            heating arbiters.
// Revision : 1.0
//============================================================================
`default_nettype none

package manor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALVE = 2'd1,
        ST_HEAT  = 2'd2,
        ST_PURGE = 2'd3
    } heat_state_t;

    localparam int c_N_ZONES = 4;
    localparam int c_VALVE_T = 4;
    localparam int c_MIN_ON  = 8;
    localparam int c_SLICE   = 32;
    localparam int c_POST_T  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/zone_rr_pick.sv
//============================================================================
// Module   : zone_rr_pick
// Summary  : Rotating-priority pick. Returns the first eligible zone after
//            ptr, wrapping modulo N_ZONES.
// Revision : 1.0
//============================================================================
`default_nettype none

module zone_rr_pick #(
    parameter int N_ZONES = 4,
    parameter int PTR_W   = 2
) (
    input  logic [N_ZONES-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   pick,
    output logic               any_elig
);

    logic [PTR_W-1:0] w_idx;

    assign any_elig = |elig;

    // Scan farthest-first so the nearest eligible zone after ptr overwrites last.
    always_comb begin
        pick  = '0;
        w_idx = '0;
        for (int k = N_ZONES; k >= 1; k--) begin
            w_idx = PTR_W'((int'(ptr) + k) % N_ZONES);
            if (elig[w_idx]) begin
                pick = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/heat_zone_scheduler.sv
//============================================================================
// Module   : heat_zone_scheduler
// Summary  : Round-robin sharing of one boiler between heating zones, with
//            valve lead, minimum-on/time-slice burn and post-burn purge.
// Revision : 1.0
//============================================================================
`default_nettype none

module heat_zone_scheduler
    import manor_pkg::*;
#(
    parameter int N_ZONES = c_N_ZONES,
    parameter int VALVE_T = c_VALVE_T,
    parameter int MIN_ON  = c_MIN_ON,
    parameter int SLICE   = c_SLICE,
    parameter int POST_T  = c_POST_T
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_ZONES-1:0] zone_req,
    input  logic [N_ZONES-1:0] nws,
    output logic [N_ZONES-1:0] grant,
    output logic               boiler_on,
    output logic               busy,
    output logic [1:0]         led
);

    localparam int c_PTR_W = $clog2(N_ZONES);
    localparam int c_CNT_W = $clog2(max3(VALVE_T, SLICE, POST_T)) + 1;

    localparam logic [c_CNT_W-1:0] c_VALVE_LAST = c_CNT_W'(VALVE_T - 1);
    localparam logic [c_CNT_W-1:0] c_MIN_LAST   = c_CNT_W'(MIN_ON - 1);
    localparam logic [c_CNT_W-1:0] c_SLICE_LAST = c_CNT_W'(SLICE - 1);
    localparam logic [c_CNT_W-1:0] c_POST_LAST  = c_CNT_W'(POST_T - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_RST    = c_PTR_W'(N_ZONES - 1);

    heat_state_t          r_state;
    heat_state_t          w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nx;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [c_PTR_W-1:0]   w_ptr_nx;
    logic [N_ZONES-1:0]   r_grant;
    logic [N_ZONES-1:0]   w_grant_nx;
    logic                 r_boiler_on;
    logic                 w_boiler_nx;

    logic [N_ZONES-1:0]   w_elig;
    logic [c_PTR_W-1:0]   w_pick;
    logic                 w_any_elig;
    logic [N_ZONES-1:0]   w_pick_oh;
    logic                 w_cur_elig;
    logic                 w_cur_req;
    logic                 w_cur_nws;
    logic                 w_other_elig;

    assign w_elig       = en ? (zone_req & nws) : '0;
    assign w_pick_oh    = N_ZONES'(1) << w_pick;
    assign w_cur_elig   = w_elig[r_ptr];
    assign w_cur_req    = zone_req[r_ptr];
    assign w_cur_nws    = nws[r_ptr];
    // Outside IDLE the grant register is exactly onehot(ptr).
    assign w_other_elig = |(w_elig & ~r_grant);

    zone_rr_pick #(
        .N_ZONES (N_ZONES),
        .PTR_W   (c_PTR_W)
    ) u_pick (
        .elig     (w_elig),
        .ptr      (r_ptr),
        .pick     (w_pick),
        .any_elig (w_any_elig)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt + 1'b1;
        w_ptr_nx    = r_ptr;
        w_grant_nx  = r_grant;
        w_boiler_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx   = '0;
                w_grant_nx = '0;
                if (w_any_elig) begin
                    w_state_nx = ST_VALVE;
                    w_grant_nx = w_pick_oh;
                    w_ptr_nx   = w_pick;
                end
            end
            ST_VALVE: begin
                if (!w_cur_elig) begin
                    w_state_nx = ST_IDLE;
                    w_grant_nx = '0;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_VALVE_LAST) begin
                    w_state_nx  = ST_HEAT;
                    w_cnt_nx    = '0;
                    w_boiler_nx = 1'b1;
                end
            end
            ST_HEAT: begin
                w_boiler_nx = 1'b1;
                if (!en || !w_cur_nws) begin
                    w_state_nx  = ST_PURGE;
                    w_cnt_nx    = '0;
                    w_boiler_nx = 1'b0;
                end else if (!w_cur_req && (r_cnt >= c_MIN_LAST)) begin
                    w_state_nx  = ST_PURGE;
                    w_cnt_nx    = '0;
                    w_boiler_nx = 1'b0;
                end else if (r_cnt == c_SLICE_LAST) begin
                    w_cnt_nx = '0;
                    if (w_other_elig) begin
                        w_state_nx  = ST_PURGE;
                        w_boiler_nx = 1'b0;
                    end
                end
            end
            ST_PURGE: begin
                if (r_cnt == c_POST_LAST) begin
                    w_cnt_nx = '0;
                    if (w_any_elig) begin
                        w_state_nx = ST_VALVE;
                        w_grant_nx = w_pick_oh;
                        w_ptr_nx   = w_pick;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_grant_nx = '0;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= c_PTR_RST;
            r_grant     <= '0;
            r_boiler_on <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_ptr       <= w_ptr_nx;
            r_grant     <= w_grant_nx;
            r_boiler_on <= w_boiler_nx;
        end
    end

    assign grant     = r_grant;
    assign boiler_on = r_boiler_on;
    assign busy      = (r_state != ST_IDLE);
    assign led       = {r_boiler_on, |r_grant};

endmodule

`default_nettype wire
